pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameters SHALL be: MEM_TIMEOUT, 255, number of consecutive MEM_WAIT cycles without ready before entering ERROR (must be at least 1).
REQ-002 Ports SHALL be (name direction width meaning), clock and reset first:
i_clk  in  1  single clock; all state changes on its rising edge
i_reset  in  1  asynchronous, active-high reset
i_id_rs1  in  5  ID-stage rs1 address
i_id_rs2  in  5  ID-stage rs2 address
i_id_rs1_used  in  1  ID instruction reads rs1
i_id_rs2_used  in  1  ID instruction reads rs2
i_ex_rd  in  5  EX-stage destination register
i_ex_reg_write  in  1  EX instruction writes rd
i_ex_is_load  in  1  EX instruction is a load (LB/LH/LW/LBU/LHU)
i_ex_redirect  in  1  EX branch taken or jump (branch_en or jump_en)
i_ex_target  in  32  redirect PC
i_mem_req  in  1  MEM stage holds a load or store
i_mem_ready  in  1  data memory done (LD_ready or SD_ready)
o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en  out  1 each  stage register enables
o_flush_if_id, o_flush_id_ex  out  1 each  insert a bubble into the named pipeReg
o_pc_sel  out  1  1 = next PC is o_pc_target
o_pc_target  out  32  redirect PC
o_state  out  2  current FSM state
o_stall_cycles  out  32  saturating count of cycles with o_pc_en=0
o_mem_timeout  out  1  sticky error flag

Function
REQ-003 The FSM states SHALL be RESET_HOLD=0, RUN=1, MEM_WAIT=2 and ERROR=3; the state and counters are registered, and all enables, flushes and PC outputs are combinational from the current state and inputs (zero latency).
REQ-004 In RESET_HOLD, all enables SHALL be 0, both flushes SHALL be 1, o_pc_sel SHALL be 0, and the next state SHALL be RUN unconditionally.
REQ-005 In RUN and in the MEM_WAIT exit cycle, priority SHALL be: memory wait, then redirect, then load-use, then normal advance.
REQ-006 Memory wait (i_mem_req=1 and i_mem_ready=0) SHALL drive all enables to 0 and all flushes to 0; from RUN the next state is MEM_WAIT.
REQ-007 Redirect SHALL drive all enables to 1, o_pc_sel=1, o_pc_target=i_ex_target and both flushes to 1; any load-use hazard in that cycle is ignored.
REQ-008 A load-use hazard exists when i_ex_is_load=1, i_ex_reg_write=1, i_ex_rd≠0, and either (i_id_rs1_used and i_id_rs1=i_ex_rd) or (i_id_rs2_used and i_id_rs2=i_ex_rd).
REQ-009 On a load-use hazard, o_pc_en and o_if_id_en SHALL be 0; o_id_ex_en, o_ex_mem_en and o_mem_wb_en SHALL be 1; o_flush_id_ex SHALL be 1, giving exactly one bubble per hazard.
REQ-010 Normal advance SHALL drive all enables to 1, all flushes to 0 and o_pc_sel to 0; o_pc_target SHALL be 0 whenever o_pc_sel=0.
REQ-011 MEM_WAIT SHALL exit when i_mem_ready=1 or i_mem_req=0; in the exit cycle, REQ-005 evaluation applies and the next state is RUN.
REQ-012 A wait counter SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle without an exit; after MEM_TIMEOUT such cycles, the next state SHALL be ERROR and o_mem_timeout SHALL set.
REQ-013 If ready arrives in the same cycle the timeout would fire, ready SHALL win.
REQ-014 ERROR SHALL hold all enables at 0 and flushes at 0 until reset; o_mem_timeout SHALL stay 1.
REQ-015 o_stall_cycles SHALL increment on every cycle with o_pc_en=0 in RUN, MEM_WAIT or ERROR, and SHALL saturate at 32'hFFFF_FFFF.

Reset
REQ-016 Asserting i_reset SHALL immediately force state RESET_HOLD, o_stall_cycles=0, o_mem_timeout=0 and the wait counter to 0, including mid-MEM_WAIT and in ERROR.
REQ-017 After i_reset deasserts, the FSM SHALL spend exactly one clock in RESET_HOLD before RUN.

Structure
REQ-018 The state encodings SHALL live in the shared define header next to the pipeReg field defines.
REQ-019 Load-use comparison SHALL be a combinational sub-module, pipe_hazard_detect; all other logic stays in pipe_ctrl.

Verification
REQ-020 Reset: assert i_reset in MEM_WAIT -> o_state=0 with no clock edge, enables 0, flushes 1; release -> o_state=1 after one clock.
REQ-021 Load-use: i_ex_is_load=1, i_ex_rd=5, i_id_rs1=5 used -> o_pc_en=0 and o_flush_id_ex=1 for exactly one cycle; the same stimulus with i_ex_rd=0 -> no stall.
REQ-022 Redirect plus hazard: i_ex_redirect=1, i_ex_target=32'h0000_0100, load-use active -> o_pc_sel=1, o_pc_target=32'h100, o_pc_en=1, both flushes 1.
REQ-023 Memory wait: i_mem_req=1, i_mem_ready=0 for 3 cycles then 1 -> enables 0 for 3 cycles, then all 1; o_stall_cycles increases by 3; state returns to RUN.
REQ-024 Timeout: MEM_TIMEOUT=4, ready never asserted -> ERROR after 4 MEM_WAIT cycles with o_mem_timeout=1; a ready asserted on the 4th cycle -> RUN, no error.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline controller: FSM state encodings and
// the bit layout of the stage-enable vector used inside pipe_ctrl.
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RESET_HOLD = 2'd0,
        ST_RUN        = 2'd1,
        ST_MEM_WAIT   = 2'd2,
        ST_ERROR      = 2'd3
    } pipe_state_t;

    // Stage-enable vector layout: {pc, if_id, id_ex, ex_mem, mem_wb}
    localparam int EN_PC     = 4;
    localparam int EN_IF_ID  = 3;
    localparam int EN_ID_EX  = 2;
    localparam int EN_EX_MEM = 1;
    localparam int EN_MEM_WB = 0;

    localparam logic [4:0] EN_ALL      = 5'b11111;
    localparam logic [4:0] EN_NONE     = 5'b00000;
    // Load-use: freeze PC and IF/ID, let the load move on behind a bubble
    localparam logic [4:0] EN_LOAD_USE = 5'b00111;

    localparam logic [31:0] STALL_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/pipe_hazard_detect.sv
// ---------------------------------------------------------------------------
// pipe_hazard_detect
// Combinational load-use hazard detection between the ID and EX stages.
// Ports:
//   i_id_rs1/i_id_rs2           ID-stage source register addresses
//   i_id_rs1_used/i_id_rs2_used ID instruction actually reads that source
//   i_ex_rd                     EX-stage destination register
//   i_ex_reg_write              EX instruction writes rd
//   i_ex_is_load                EX instruction is a load
//   o_load_use                  1 = ID needs a value the EX load has not produced
// ---------------------------------------------------------------------------
module pipe_hazard_detect (
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_id_rs1_used,
    input  logic       i_id_rs2_used,
    input  logic [4:0] i_ex_rd,
    input  logic       i_ex_reg_write,
    input  logic       i_ex_is_load,
    output logic       o_load_use
);

    logic w_rs1_match;
    logic w_rs2_match;
    logic w_ex_load_wr;

    // x0 is hardwired to zero, so a load targeting it never creates a hazard
    assign w_ex_load_wr = i_ex_is_load & i_ex_reg_write & (i_ex_rd != 5'd0);
    assign w_rs1_match  = i_id_rs1_used & (i_id_rs1 == i_ex_rd);
    assign w_rs2_match  = i_id_rs2_used & (i_id_rs2 == i_ex_rd);
    assign o_load_use   = w_ex_load_wr & (w_rs1_match | w_rs2_match);

endmodule

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
// Pipeline sequencing controller: stage enables, bubbles, PC redirect,
// memory-wait stalls with timeout, and a saturating stall-cycle counter.
//
// state         | meaning
// --------------+---------------------------------------------------------
// RESET_HOLD(0) | one cycle after reset: everything frozen, both pipeRegs flushed
// RUN(1)        | normal issue; memory wait, redirect, load-use handled here
// MEM_WAIT(2)   | waiting on data memory; counts towards MEM_TIMEOUT
// ERROR(3)      | memory timed out; pipeline frozen until reset
//
// Ports:
//   i_clk, i_reset                 clock, async active-high reset
//   i_id_*, i_ex_*                 ID/EX operand and control info
//   i_mem_req, i_mem_ready         MEM-stage access handshake
//   o_*_en                         stage register enables
//   o_flush_if_id, o_flush_id_ex   bubble insertion
//   o_pc_sel, o_pc_target          PC redirect
//   o_state                        current FSM state
//   o_stall_cycles                 saturating count of cycles with PC frozen
//   o_mem_timeout                  sticky memory-timeout flag
// ---------------------------------------------------------------------------
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [4:0]  i_id_rs1,
    input  logic [4:0]  i_id_rs2,
    input  logic        i_id_rs1_used,
    input  logic        i_id_rs2_used,
    input  logic [4:0]  i_ex_rd,
    input  logic        i_ex_reg_write,
    input  logic        i_ex_is_load,
    input  logic        i_ex_redirect,
    input  logic [31:0] i_ex_target,
    input  logic        i_mem_req,
    input  logic        i_mem_ready,
    output logic        o_pc_en,
    output logic        o_if_id_en,
    output logic        o_id_ex_en,
    output logic        o_ex_mem_en,
    output logic        o_mem_wb_en,
    output logic        o_flush_if_id,
    output logic        o_flush_id_ex,
    output logic        o_pc_sel,
    output logic [31:0] o_pc_target,
    output logic [1:0]  o_state,
    output logic [31:0] o_stall_cycles,
    output logic        o_mem_timeout
);

    // Counter only has to reach MEM_TIMEOUT-1
    localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    pipe_state_t      r_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [31:0]      r_stall_cycles;
    logic             r_mem_timeout;

    logic             w_load_use;
    logic             w_mem_wait;
    logic [4:0]       w_en;
    logic             w_flush_if_id;
    logic             w_flush_id_ex;
    logic             w_pc_sel;
    logic [31:0]      w_pc_target;

    pipe_hazard_detect u_hazard (
        .i_id_rs1       (i_id_rs1),
        .i_id_rs2       (i_id_rs2),
        .i_id_rs1_used  (i_id_rs1_used),
        .i_id_rs2_used  (i_id_rs2_used),
        .i_ex_rd        (i_ex_rd),
        .i_ex_reg_write (i_ex_reg_write),
        .i_ex_is_load   (i_ex_is_load),
        .o_load_use     (w_load_use)
    );

    assign w_mem_wait = i_mem_req & ~i_mem_ready;

    // RUN and MEM_WAIT share one decode: a MEM_WAIT cycle that is not exiting
    // is exactly a memory-wait cycle, so the same priority chain covers both.
    always_comb begin
        w_en          = EN_ALL;
        w_flush_if_id = 1'b0;
        w_flush_id_ex = 1'b0;
        w_pc_sel      = 1'b0;
        w_pc_target   = 32'd0;
        case (r_state)
            ST_RESET_HOLD: begin
                w_en          = EN_NONE;
                w_flush_if_id = 1'b1;
                w_flush_id_ex = 1'b1;
            end
            ST_ERROR: begin
                w_en = EN_NONE;
            end
            default: begin
                if (w_mem_wait) begin
                    w_en = EN_NONE;
                end else if (i_ex_redirect) begin
                    w_pc_sel      = 1'b1;
                    w_pc_target   = i_ex_target;
                    w_flush_if_id = 1'b1;
                    w_flush_id_ex = 1'b1;
                end else if (w_load_use) begin
                    w_en          = EN_LOAD_USE;
                    w_flush_id_ex = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= ST_RESET_HOLD;
            r_wait_cnt     <= '0;
            r_stall_cycles <= 32'd0;
            r_mem_timeout  <= 1'b0;
        end else begin
            if ((r_state != ST_RESET_HOLD) && !w_en[EN_PC] &&
                (r_stall_cycles != STALL_MAX)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            case (r_state)
                ST_RESET_HOLD: r_state <= ST_RUN;
                ST_RUN: begin
                    if (w_mem_wait) begin
                        r_state    <= ST_MEM_WAIT;
                        r_wait_cnt <= '0;
                    end
                end
                ST_MEM_WAIT: begin
                    // Exit is checked first so a late ready beats the timeout
                    if (!w_mem_wait) begin
                        r_state <= ST_RUN;
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        r_state       <= ST_ERROR;
                        r_mem_timeout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                ST_ERROR: begin
                    r_state       <= ST_ERROR;
                    r_mem_timeout <= 1'b1;
                end
                default: r_state <= ST_RESET_HOLD;
            endcase
        end
    end

    assign o_pc_en        = w_en[EN_PC];
    assign o_if_id_en     = w_en[EN_IF_ID];
    assign o_id_ex_en     = w_en[EN_ID_EX];
    assign o_ex_mem_en    = w_en[EN_EX_MEM];
    assign o_mem_wb_en    = w_en[EN_MEM_WB];
    assign o_flush_if_id  = w_flush_if_id;
    assign o_flush_id_ex  = w_flush_id_ex;
    assign o_pc_sel       = w_pc_sel;
    assign o_pc_target    = w_pc_target;
    assign o_state        = r_state;
    assign o_stall_cycles = r_stall_cycles;
    assign o_mem_timeout  = r_mem_timeout;

endmodule
